dual_master_arbiter: RTL and testbench
======================================

DUAL_MASTER_ARBITER -- requirements
Module: dual_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning cycles a granted master may stay idle (no m<i>_master_valid) before the grant is revoked; legal range 2..31.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have, for i in {1,2}: m<i>_req  input  1  master requests bus tenure, held high for whole transaction.
REQ-005 SHALL have, for i in {1,2}: m<i>_grant  output  1  master owns the downstream port.
REQ-006 SHALL have, for i in {1,2}: m<i>_mode, m<i>_wr_bus, m<i>_master_valid, m<i>_master_ready  input  1 each  master-side serial bus signals.
REQ-007 SHALL have, for i in {1,2}: m<i>_rd_bus, m<i>_ack, m<i>_slave_ready, m<i>_slave_valid  output  1 each  returned bus signals.
REQ-008 SHALL have d_mode, d_wr_bus, d_master_valid, d_master_ready  output  1 each  to the address-decoding arbiter.
REQ-009 SHALL have d_rd_bus, d_ack, d_slave_ready, d_slave_valid  input  1 each  from the address-decoding arbiter.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_M1, GRANT_M2, RELEASE, state registered.
REQ-011 m<i>_grant SHALL be 1 only in GRANT_M<i>; decoded from registered state, so grant rises one cycle after req is sampled.
REQ-012 IDLE: one eligible requester -> GRANT of that master; both -> GRANT of master not in last_grant; none -> IDLE.
REQ-013 GRANT_M<i>: m<i>_req low -> RELEASE; idle counter reaching TIMEOUT-1 with no m<i>_master_valid yet seen -> RELEASE and set blocked<i>; else stay.
REQ-014 RELEASE SHALL last exactly one cycle, all d_* outputs 0; next state chosen by REQ-012 rules (back-to-back handover permitted).
REQ-015 last_grant SHALL update on every entry to a GRANT state; reset value M2 so M1 wins the first tie.
REQ-016 Idle counter (5 bits) SHALL clear on GRANT entry, increment each GRANT cycle until master_valid first seen, then freeze; a tenure with valid seen never times out.
REQ-017 blocked<i> SHALL make master i ineligible; cleared when m<i>_req is sampled low.
REQ-018 In GRANT_M<i>, d_* outputs SHALL equal m<i>_* combinationally, and m<i>_rd_bus/ack/slave_ready/slave_valid SHALL equal d_* combinationally.
REQ-019 Non-granted master's return outputs and all d_* outputs outside GRANT states SHALL be 0.
REQ-020 Requests arriving during a grant SHALL wait; no preemption.

Reset
REQ-021 rstn low SHALL asynchronously force state IDLE, last_grant M2, counter 0, blocked1/2 0; all outputs 0 while in reset.
REQ-022 Reset mid-tenure SHALL drop grant immediately; after release, arbitration restarts from IDLE with no memory of prior tenure.

Structure
REQ-023 Package bus_arb_pkg SHALL hold the state enum, the master-id enum {M1, M2} and TIMEOUT default constant.
REQ-024 Sub-module rr_picker (combinational: two eligible bits + last_grant -> winner id, valid) SHALL be the only child.

Verification
REQ-025 m1_req=1 at cycle 0, m2_req=0 -> m1_grant=1 from cycle 1; m1_wr_bus toggles appear on d_wr_bus same cycle; m2_* returns 0.
REQ-026 Both reqs rise same cycle after reset -> M1 granted; M1 drops req -> 1 RELEASE cycle, then M2 granted; next tie -> M1.
REQ-027 M1 granted, m1_master_valid never asserted, TIMEOUT=16 -> grant drops after 16 grant cycles; M1 holding req stays ungranted until req low one cycle.
REQ-028 M1 asserts master_valid in cycle 3 of tenure, holds req 40 cycles -> no timeout; d_ack/d_slave_ready mirrored to m1 only.
REQ-029 rstn low during GRANT_M2 -> m2_grant and all d_* 0 same cycle, without clock; after rstn high with both reqs -> M1 granted.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master bus arbiter: FSM states, master ids,
// idle-counter width and the default idle timeout.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2,
    RELEASE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_id_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = 5;

  function automatic arb_state_e grant_state(input master_id_e id);
    return (id == M1) ? GRANT_M1 : GRANT_M2;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin pick: a lone eligible master wins outright; on a tie the
// master that did not hold the last grant wins. Purely combinational.
module rr_picker (
  input  logic [1:0] elig_i,
  input  logic       last_grant_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |elig_i;
    winner_o = 1'b0;
    case (elig_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dual_master_arbiter.sv
// Arbitrates two serial-bus masters onto one downstream port, with round-robin
// ties, a one-cycle release gap and revocation of tenures that never go valid.
module dual_master_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,

  input  logic m1_req,
  output logic m1_grant,
  input  logic m1_mode,
  input  logic m1_wr_bus,
  input  logic m1_master_valid,
  input  logic m1_master_ready,
  output logic m1_rd_bus,
  output logic m1_ack,
  output logic m1_slave_ready,
  output logic m1_slave_valid,

  input  logic m2_req,
  output logic m2_grant,
  input  logic m2_mode,
  input  logic m2_wr_bus,
  input  logic m2_master_valid,
  input  logic m2_master_ready,
  output logic m2_rd_bus,
  output logic m2_ack,
  output logic m2_slave_ready,
  output logic m2_slave_valid,

  output logic d_mode,
  output logic d_wr_bus,
  output logic d_master_valid,
  output logic d_master_ready,
  input  logic d_rd_bus,
  input  logic d_ack,
  input  logic d_slave_ready,
  input  logic d_slave_valid
);

  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

  // Per-master vectors, index 0 = M1, index 1 = M2.
  logic [1:0] req;
  logic [1:0] mode;
  logic [1:0] wr_bus;
  logic [1:0] mvalid;
  logic [1:0] mready;
  logic [1:0] grant;
  logic [1:0] rd_bus_ret;
  logic [1:0] ack_ret;
  logic [1:0] sready_ret;
  logic [1:0] svalid_ret;

  assign req    = {m2_req,          m1_req};
  assign mode   = {m2_mode,         m1_mode};
  assign wr_bus = {m2_wr_bus,       m1_wr_bus};
  assign mvalid = {m2_master_valid, m1_master_valid};
  assign mready = {m2_master_ready, m1_master_ready};

  arb_state_e             state_q, state_d;
  master_id_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   seen_q, seen_d;
  logic [1:0]             blocked_q, blocked_d;

  logic [1:0]             elig;
  logic                   pick_bit;
  logic                   pick_valid;
  master_id_e             pick_id;
  logic                   cur;

  assign elig    = req & ~blocked_q;
  assign pick_id = master_id_e'(pick_bit);
  assign cur     = (state_q == GRANT_M2);

  rr_picker u_picker (
    .elig_i       (elig),
    .last_grant_i (last_grant_q),
    .winner_o     (pick_bit),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= M2;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      blocked_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      blocked_q    <= blocked_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    // A block lasts only until the master lets go of its request.
    blocked_d    = blocked_q & req;

    case (state_q)
      IDLE, RELEASE: begin
        if (pick_valid) begin
          state_d      = grant_state(pick_id);
          last_grant_d = pick_id;
          cnt_d        = '0;
          seen_d       = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT_M1, GRANT_M2: begin
        if (!req[cur]) begin
          state_d = RELEASE;
        end else if (!seen_q && !mvalid[cur] && (cnt_q == IDLE_LIMIT)) begin
          // Master sat on the bus without ever driving valid: revoke and
          // keep it out until it drops its request.
          state_d        = RELEASE;
          blocked_d[cur] = 1'b1;
        end else if (!seen_q) begin
          if (mvalid[cur]) begin
            seen_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant[0] = (state_q == GRANT_M1);
  assign grant[1] = (state_q == GRANT_M2);

  // Grant is one-hot (or zero), so an AND-OR forms the downstream mux.
  assign d_mode         = |(grant & mode);
  assign d_wr_bus       = |(grant & wr_bus);
  assign d_master_valid = |(grant & mvalid);
  assign d_master_ready = |(grant & mready);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rd_bus_ret[gi] = grant[gi] & d_rd_bus;
    assign ack_ret[gi]    = grant[gi] & d_ack;
    assign sready_ret[gi] = grant[gi] & d_slave_ready;
    assign svalid_ret[gi] = grant[gi] & d_slave_valid;
  end

  assign m1_grant       = grant[0];
  assign m1_rd_bus      = rd_bus_ret[0];
  assign m1_ack         = ack_ret[0];
  assign m1_slave_ready = sready_ret[0];
  assign m1_slave_valid = svalid_ret[0];

  assign m2_grant       = grant[1];
  assign m2_rd_bus      = rd_bus_ret[1];
  assign m2_ack         = ack_ret[1];
  assign m2_slave_ready = sready_ret[1];
  assign m2_slave_valid = svalid_ret[1];

endmodule

// File: tb/tb_dual_master_arbiter.sv
// Randomised check of dual_master_arbiter against a tenure-level model, plus
// directed scenarios pinned with literal expectations.
module tb_dual_master_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:2] req, mode, wr, mv, mr;
  logic d_rd, d_ack, d_sr, d_sv;

  logic m1_grant, m2_grant;
  logic m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid;
  logic m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid;
  logic d_mode, d_wr_bus, d_master_valid, d_master_ready;

  int tests = 0;
  int fails = 0;

  // Model: who owns the bus (0 = nobody), who won last, tenure progress, blocks.
  int owner;
  int last;
  int age;
  bit seen;
  bit [1:2] blocked;
  bit [1:2] lazy;

  always #5 clk = ~clk;

  dual_master_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .m1_req(req[1]), .m1_grant(m1_grant), .m1_mode(mode[1]), .m1_wr_bus(wr[1]),
    .m1_master_valid(mv[1]), .m1_master_ready(mr[1]),
    .m1_rd_bus(m1_rd_bus), .m1_ack(m1_ack), .m1_slave_ready(m1_slave_ready),
    .m1_slave_valid(m1_slave_valid),
    .m2_req(req[2]), .m2_grant(m2_grant), .m2_mode(mode[2]), .m2_wr_bus(wr[2]),
    .m2_master_valid(mv[2]), .m2_master_ready(mr[2]),
    .m2_rd_bus(m2_rd_bus), .m2_ack(m2_ack), .m2_slave_ready(m2_slave_ready),
    .m2_slave_valid(m2_slave_valid),
    .d_mode(d_mode), .d_wr_bus(d_wr_bus), .d_master_valid(d_master_valid),
    .d_master_ready(d_master_ready),
    .d_rd_bus(d_rd), .d_ack(d_ack), .d_slave_ready(d_sr), .d_slave_valid(d_sv)
  );

  function automatic logic [13:0] dut_vec();
    return {m1_grant, m2_grant, m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid,
            m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid,
            d_mode, d_wr_bus, d_master_valid, d_master_ready};
  endfunction

  function automatic logic [13:0] model_vec();
    logic [3:0] ret, dn;
    ret = {d_rd, d_ack, d_sr, d_sv};
    dn  = 4'b0000;
    if (owner == 1) dn = {mode[1], wr[1], mv[1], mr[1]};
    if (owner == 2) dn = {mode[2], wr[2], mv[2], mr[2]};
    return {owner == 1, owner == 2,
            (owner == 1) ? ret : 4'b0000,
            (owner == 2) ? ret : 4'b0000,
            dn};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    owner   = 0;
    last    = 2;
    age     = 0;
    seen    = 1'b0;
    blocked = '0;
  endtask

  // One clock edge of the arbitration rules, expressed per tenure.
  task automatic model_update();
    bit [1:2] nb;
    bit e1, e2;
    int o;
    nb = blocked & req;
    o  = owner;
    if (o != 0) begin
      if (!req[o]) begin
        owner = 0;
      end else if (!(seen || mv[o]) && age == TO - 1) begin
        owner = 0;
        nb[o] = 1'b1;
      end else begin
        seen = seen | mv[o];
        age++;
      end
    end else begin
      e1 = req[1] & ~blocked[1];
      e2 = req[2] & ~blocked[2];
      if (e1 && e2)  owner = (last == 1) ? 2 : 1;
      else if (e1)   owner = 1;
      else if (e2)   owner = 2;
      else           owner = 0;
      if (owner != 0) begin
        last = owner;
        age  = 0;
        seen = 1'b0;
      end
    end
    blocked = nb;
  endtask

  // Advance one cycle: model follows the edge, every output compared at negedge.
  task automatic step();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_update();
    @(negedge clk);
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic clear_inputs();
    req = '0; mode = '0; wr = '0; mv = '0; mr = '0;
    d_rd = 1'b0; d_ack = 1'b0; d_sr = 1'b0; d_sv = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    model_reset();
    clear_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    lazy = '0;
    model_reset();
    @(negedge clk);

    // Reset state
    apply_reset();
    check("reset_outputs", dut_vec(), 14'd0);

    // Lone M1 request: grant next cycle, wr_bus and returns routed combinationally
    req[1] = 1'b1;
    step();
    check("m1_grant_c1", {m1_grant, m2_grant}, 14'b10);
    wr[1] = 1'b1; d_ack = 1'b1;
    #1;
    check("d_wr_bus_mirror", {d_wr_bus, m1_ack, m2_ack}, 14'b110);
    check("mirror_model", dut_vec(), model_vec());
    wr[1] = 1'b0; d_ack = 1'b0; req[1] = 1'b0;
    step();
    check("release_gap", {m1_grant, m2_grant, d_wr_bus}, 14'b000);
    step();

    // Tie after reset -> M1, handover via one RELEASE cycle, next tie -> M1
    apply_reset();
    req = 2'b11; mv[1] = 1'b1;
    step();
    check("tie1_m1", {m1_grant, m2_grant}, 14'b10);
    step(); step();
    req[1] = 1'b0;
    step();
    check("handover_release", {m1_grant, m2_grant}, 14'b00);
    step();
    check("handover_m2", {m1_grant, m2_grant}, 14'b01);
    req[1] = 1'b1; mv = '0;
    step();
    check("no_preempt", {m1_grant, m2_grant}, 14'b01);
    req[2] = 1'b0;
    step();
    req[2] = 1'b1;
    step();
    check("tie2_m1", {m1_grant, m2_grant}, 14'b10);
    req = '0;
    step(); step();

    // Timeout: 16 grant cycles without valid, then blocked until req drops
    apply_reset();
    req[1] = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == 1 || k == TO) check($sformatf("to_grant_%0d", k), {13'd0, m1_grant}, 14'd1);
    end
    step();
    check("to_revoked", {13'd0, m1_grant}, 14'd0);
    step(); step(); step();
    check("to_blocked", {13'd0, m1_grant}, 14'd0);
    req[1] = 1'b0;
    step();
    req[1] = 1'b1;
    step();
    check("to_unblocked", {13'd0, m1_grant}, 14'd1);
    req[1] = 1'b0;
    step(); step();

    // Valid in tenure cycle 3 -> 40-cycle tenure survives, returns go to M1 only
    apply_reset();
    req[1] = 1'b1;
    step(); step();
    mv[1] = 1'b1;
    step();
    mv[1] = 1'b0; req[2] = 1'b1;
    for (int k = 0; k < 37; k++) begin
      d_ack = 1'($urandom_range(0, 1));
      d_sr  = 1'($urandom_range(0, 1));
      step();
    end
    check("long_tenure", {m1_grant, m2_grant}, 14'b10);
    d_ack = 1'b1; d_sr = 1'b1;
    #1;
    check("ack_to_m1", {m1_ack, m1_slave_ready, m2_ack, m2_slave_ready}, 14'b1100);
    req[1] = 1'b0; d_ack = 1'b0; d_sr = 1'b0;
    step(); step();
    check("m2_after_long", {m1_grant, m2_grant}, 14'b01);

    // Asynchronous reset during GRANT_M2
    apply_reset();
    req[2] = 1'b1;
    step();
    wr[2] = 1'b1; mv[2] = 1'b1;
    #1;
    check("m2_drive", {m2_grant, d_wr_bus, d_master_valid}, 14'b111);
    #1 rstn = 1'b0;
    #1;
    model_reset();
    check("async_drop", {m2_grant, d_mode, d_wr_bus, d_master_valid, d_master_ready}, 14'd0);
    req = 2'b11; wr = '0; mv = '0;
    step(); step();
    rstn = 1'b1;
    step();
    check("post_rst_m1", {m1_grant, m2_grant}, 14'b10);

    // Randomised traffic with sparse asynchronous resets
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 1; i <= 2; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 24) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i]  = 1'b1;
          lazy[i] = ($urandom_range(0, 2) == 0);
        end
        mv[i]   = !lazy[i] && req[i] && ($urandom_range(0, 7) == 0);
        mode[i] = 1'($urandom_range(0, 1));
        wr[i]   = 1'($urandom_range(0, 1));
        mr[i]   = 1'($urandom_range(0, 1));
      end
      d_rd  = 1'($urandom_range(0, 1));
      d_ack = 1'($urandom_range(0, 1));
      d_sr  = 1'($urandom_range(0, 1));
      d_sv  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("rand_async_rst", dut_vec(), model_vec());
        step();
        rstn = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
